// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: ownership state and the
// write-type encodings understood by the data memory.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } own_e;

    localparam logic [2:0] WT_BYTE  = 3'b000;
    localparam logic [2:0] WT_HALF  = 3'b001;
    localparam logic [2:0] WT_WORD  = 3'b010;
    localparam logic [2:0] WT_BYTEU = 3'b100;
    localparam logic [2:0] WT_HALFU = 3'b101;

endpackage

// File: rtl/dmem_arbiter_if.sv
// One requester's view of the shared data-memory port: request side
// (master = requester) and arbiter side (slave).
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);

    logic              req;
    logic              lock;
    logic              we;
    logic [2:0]        wtype;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, lock, we, wtype, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, lock, we, wtype, addr, wdata,
        output gnt, rvalid, rdata
    );

endinterface

// File: rtl/dmem_arb_lock_timer.sv
// Counts consecutive locked grants to one owner and flags expiry
// once LOCK_MAX further grants have been taken under the lock.
module dmem_arb_lock_timer #(
    parameter int LOCK_MAX = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic hold,
    output logic expired
);

    localparam int CW = $clog2(LOCK_MAX + 1);

    logic [CW-1:0] lcnt_q;
    logic [CW-1:0] lcnt_d;

    assign expired = (lcnt_q >= CW'(LOCK_MAX));

    always_comb begin
        lcnt_d = '0;
        if (hold) begin
            lcnt_d = lcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lcnt_q <= '0;
        end else begin
            lcnt_q <= lcnt_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between two requesters,
// with bounded locking. Define DMEM_ARB_STATS_EN for grant/conflict counters.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int LOCK_MAX = 16
) (
    input  logic              clk,
    input  logic              rst,
    dmem_arbiter_if.slave     r0,
    dmem_arbiter_if.slave     r1,
    output logic              mem_we,
    output logic [2:0]        mem_wtype,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [31:0]       stat_gnt0,
    output logic [31:0]       stat_gnt1,
    output logic [31:0]       stat_conflict
`endif
);

    own_e own_q, own_d;
    logic prio_q, prio_d;
    logic rv0_q, rv0_d;
    logic rv1_q, rv1_d;
    logic win0, win1, sel1;
    logic expired, hold;

    dmem_arb_lock_timer #(
        .LOCK_MAX(LOCK_MAX)
    ) u_lock_timer (
        .clk    (clk),
        .rst    (rst),
        .hold   (hold),
        .expired(expired)
    );

    // An expired owner must yield to a waiting peer regardless of prio.
    always_comb begin
        win0   = 1'b0;
        win1   = 1'b0;
        sel1   = 1'b0;
        prio_d = prio_q;
        if (rst) begin
            win0 = 1'b0;
        end else if (own_q == OWN0 && r0.req && !expired) begin
            win0 = 1'b1;
        end else if (own_q == OWN1 && r1.req && !expired) begin
            win1 = 1'b1;
        end else if (r0.req && r1.req) begin
            sel1   = expired ? (own_q == OWN0) : prio_q;
            win1   = sel1;
            win0   = !sel1;
            prio_d = !sel1;
        end else begin
            win0 = r0.req;
            win1 = r1.req;
        end
    end

    always_comb begin
        own_d = IDLE;
        if (win0 && r0.lock) begin
            own_d = OWN0;
        end else if (win1 && r1.lock) begin
            own_d = OWN1;
        end
        hold  = (own_d != IDLE) && (own_d == own_q) && !expired;
        rv0_d = win0 && !r0.we;
        rv1_d = win1 && !r1.we;
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_wtype = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (win0) begin
            mem_we    = r0.we;
            mem_wtype = r0.wtype;
            mem_addr  = r0.addr;
            mem_wdata = r0.wdata;
        end else if (win1) begin
            mem_we    = r1.we;
            mem_wtype = r1.wtype;
            mem_addr  = r1.addr;
            mem_wdata = r1.wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            own_q  <= IDLE;
            prio_q <= 1'b0;
            rv0_q  <= 1'b0;
            rv1_q  <= 1'b0;
        end else begin
            own_q  <= own_d;
            prio_q <= prio_d;
            rv0_q  <= rv0_d;
            rv1_q  <= rv1_d;
        end
    end

    assign r0.gnt    = win0;
    assign r1.gnt    = win1;
    assign r0.rvalid = rv0_q;
    assign r1.rvalid = rv1_q;
    assign r0.rdata  = rv0_q ? mem_rdata : '0;
    assign r1.rdata  = rv1_q ? mem_rdata : '0;

`ifdef DMEM_ARB_STATS_EN
    logic [31:0] sg0_q, sg0_d;
    logic [31:0] sg1_q, sg1_d;
    logic [31:0] scf_q, scf_d;

    always_comb begin
        sg0_d = sg0_q + {31'd0, win0};
        sg1_d = sg1_q + {31'd0, win1};
        scf_d = scf_q + {31'd0, r0.req && r1.req};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sg0_q <= '0;
            sg1_q <= '0;
            scf_q <= '0;
        end else begin
            sg0_q <= sg0_d;
            sg1_q <= sg1_d;
            scf_q <= scf_d;
        end
    end

    assign stat_gnt0     = sg0_q;
    assign stat_gnt1     = sg1_q;
    assign stat_conflict = scf_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter (LOCK_MAX=4); stats checks are
// included when DMEM_ARB_STATS_EN is defined.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) r0 ();
    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) r1 ();

    logic        mem_we;
    logic [2:0]  mem_wtype;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef DMEM_ARB_STATS_EN
    logic [31:0] stat_gnt0, stat_gnt1, stat_conflict;
`endif

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .LOCK_MAX(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .r0       (r0),
        .r1       (r1),
        .mem_we   (mem_we),
        .mem_wtype(mem_wtype),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_STATS_EN
        ,
        .stat_gnt0    (stat_gnt0),
        .stat_gnt1    (stat_gnt1),
        .stat_conflict(stat_conflict)
`endif
    );

    function automatic logic [31:0] pat(input logic [31:0] a);
        return (a * 32'h9E37) ^ 32'h5A5A_0000;
    endfunction

    // Memory: one-cycle read latency, unwritten words read as pat(addr).
    logic [31:0] mem [logic [31:0]];
    always @(posedge clk) begin
        logic [31:0] rd;
        rd = mem.exists(mem_addr) ? mem[mem_addr] : pat(mem_addr);
        if (mem_we) mem[mem_addr] = mem_wdata;
        mem_rdata <= rd;
    end

    typedef struct {
        bit          who;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int n, input bit req, input bit lock,
                         input bit we, input logic [2:0] wt,
                         input logic [31:0] a, input logic [31:0] d);
        if (n == 0) begin
            r0.req = req; r0.lock = lock; r0.we = we;
            r0.wtype = wt; r0.addr = a; r0.wdata = d;
        end else begin
            r1.req = req; r1.lock = lock; r1.we = we;
            r1.wtype = wt; r1.addr = a; r1.wdata = d;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive(0, 1, 0, 1, WT_WORD, 32'h10, 32'h1111);
        drive(1, 1, 0, 1, WT_WORD, 32'h20, 32'h2222);
        tick;
        tick;
        #1;
        n_chk++;
        if ({r1.gnt, r0.gnt} !== 2'b00)
            $display("FAIL reset_gnt got %b want 00", {r1.gnt, r0.gnt});
        else n_pass++;
        n_chk++;
        if (mem_we !== 1'b0 || mem_addr !== 32'h0)
            $display("FAIL reset_mem got we=%b addr=%h want 0/0", mem_we, mem_addr);
        else n_pass++;
        n_chk++;
        if ({r1.rvalid, r0.rvalid} !== 2'b00 || r0.rdata !== 0 || r1.rdata !== 0)
            $display("FAIL reset_rvalid got %b want 00", {r1.rvalid, r0.rvalid});
        else n_pass++;
        drive(0, 1, 0, 0, WT_WORD, 32'h10, 0);
        drive(1, 1, 0, 0, WT_WORD, 32'h20, 0);
        rst = 1'b0;
        #1;
        n_chk++;
        if ({r1.gnt, r0.gnt} !== 2'b01)
            $display("FAIL reset_first_winner got %b want 01", {r1.gnt, r0.gnt});
        else n_pass++;
        sb.push_back('{1'b0, pat(32'h10)});
    endtask

    task automatic test_contention;
        exp_t e;
        logic [1:0] erv;
        logic [31:0] a0, a1, got;
        bit w;
        for (int k = 0; k < 5; k++) begin
            tick;
            a0 = 32'h100 + 32'(k * 4);
            a1 = 32'h200 + 32'(k * 4);
            drive(0, k < 4, 0, 0, WT_WORD, a0, 0);
            drive(1, k < 4, 0, 0, WT_WORD, a1, 0);
            #1;
            erv = 2'b00;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                erv = e.who ? 2'b10 : 2'b01;
            end
            n_chk++;
            if ({r1.rvalid, r0.rvalid} !== erv)
                $display("FAIL contention_rvalid k=%0d got %b want %b", k, {r1.rvalid, r0.rvalid}, erv);
            else n_pass++;
            if (erv != 2'b00) begin
                got = e.who ? r1.rdata : r0.rdata;
                n_chk++;
                if (got !== e.data)
                    $display("FAIL contention_rdata k=%0d got %h want %h", k, got, e.data);
                else n_pass++;
            end
            if (k < 4) begin
                w = (k % 2 == 0);
                n_chk++;
                if ({r1.gnt, r0.gnt} !== (w ? 2'b10 : 2'b01))
                    $display("FAIL contention_gnt k=%0d got %b want %0d", k, {r1.gnt, r0.gnt}, w);
                else n_pass++;
                n_chk++;
                if (mem_addr !== (w ? a1 : a0))
                    $display("FAIL contention_addr k=%0d got %h want %h", k, mem_addr, w ? a1 : a0);
                else n_pass++;
                sb.push_back('{w, pat(w ? a1 : a0)});
            end
        end
    endtask

    task automatic test_solo;
        exp_t e;
        logic [1:0] erv;
        logic [31:0] got;
        for (int k = 0; k < 3; k++) begin
            tick;
            drive(0, 0, 0, 0, WT_WORD, 0, 0);
            if (k == 0) drive(1, 1, 0, 1, WT_WORD, 32'h40, 32'hDEADBEEF);
            else if (k == 1) drive(1, 1, 0, 0, WT_WORD, 32'h40, 0);
            else drive(1, 0, 0, 0, WT_WORD, 0, 0);
            #1;
            erv = 2'b00;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                erv = e.who ? 2'b10 : 2'b01;
            end
            n_chk++;
            if ({r1.rvalid, r0.rvalid} !== erv)
                $display("FAIL solo_rvalid k=%0d got %b want %b", k, {r1.rvalid, r0.rvalid}, erv);
            else n_pass++;
            if (erv != 2'b00) begin
                got = e.who ? r1.rdata : r0.rdata;
                n_chk++;
                if (got !== e.data || r0.rdata !== 32'h0)
                    $display("FAIL solo_rdata k=%0d got %h want %h", k, got, e.data);
                else n_pass++;
            end
            n_chk++;
            if ({r1.gnt, r0.gnt} !== (k < 2 ? 2'b10 : 2'b00))
                $display("FAIL solo_gnt k=%0d got %b", k, {r1.gnt, r0.gnt});
            else n_pass++;
            if (k == 0) begin
                n_chk++;
                if (mem_we !== 1'b1 || mem_wtype !== 3'b010 || mem_wdata !== 32'hDEADBEEF)
                    $display("FAIL solo_store got we=%b wt=%b wd=%h want 1/010/deadbeef",
                             mem_we, mem_wtype, mem_wdata);
                else n_pass++;
            end
            if (k == 1) begin
                n_chk++;
                if (mem_we !== 1'b0 || mem_addr !== 32'h40)
                    $display("FAIL solo_load got we=%b addr=%h want 0/40", mem_we, mem_addr);
                else n_pass++;
                sb.push_back('{1'b1, 32'hDEADBEEF});
            end
        end
    endtask

    task automatic test_lock_expiry;
        exp_t e;
        logic [1:0] erv;
        logic [31:0] a0, a1, got;
        bit w;
        tick;
        rst = 1'b1;
        drive(0, 0, 0, 0, WT_WORD, 0, 0);
        drive(1, 0, 0, 0, WT_WORD, 0, 0);
        tick;
        rst = 1'b0;
        for (int k = 0; k < 7; k++) begin
            if (k > 0) tick;
            a0 = 32'h300 + 32'(k * 4);
            a1 = 32'h380 + 32'(k * 4);
            drive(0, k < 6, 1, 0, WT_WORD, a0, 0);
            drive(1, k < 6, 0, 0, WT_WORD, a1, 0);
            #1;
            erv = 2'b00;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                erv = e.who ? 2'b10 : 2'b01;
            end
            n_chk++;
            if ({r1.rvalid, r0.rvalid} !== erv)
                $display("FAIL lock_rvalid k=%0d got %b want %b", k, {r1.rvalid, r0.rvalid}, erv);
            else n_pass++;
            if (erv != 2'b00) begin
                got = e.who ? r1.rdata : r0.rdata;
                n_chk++;
                if (got !== e.data)
                    $display("FAIL lock_rdata k=%0d got %h want %h", k, got, e.data);
                else n_pass++;
            end
            if (k < 6) begin
                w = (k == 5);
                n_chk++;
                if ({r1.gnt, r0.gnt} !== (w ? 2'b10 : 2'b01))
                    $display("FAIL lock_gnt k=%0d got %b want %0d", k, {r1.gnt, r0.gnt}, w);
                else n_pass++;
                sb.push_back('{w, pat(w ? a1 : a0)});
            end
        end
    endtask

    task automatic test_midlock_reset;
        exp_t e;
        logic [1:0] erv, eg;
        logic [31:0] got;
        for (int k = 0; k < 5; k++) begin
            tick;
            eg = 2'b00;
            case (k)
                0: begin
                    drive(0, 1, 0, 0, WT_WORD, 32'h10, 0);
                    drive(1, 1, 0, 0, WT_WORD, 32'h20, 0);
                    eg = 2'b01;
                end
                1: begin
                    drive(0, 0, 0, 0, WT_WORD, 0, 0);
                    drive(1, 1, 1, 0, WT_WORD, 32'h24, 0);
                    eg = 2'b10;
                end
                2: begin
                    drive(1, 1, 1, 0, WT_WORD, 32'h28, 0);
                    eg = 2'b10;
                end
                3: begin
                    rst = 1'b0;
                    drive(0, 1, 0, 0, WT_WORD, 32'h30, 0);
                    drive(1, 1, 1, 0, WT_WORD, 32'h2C, 0);
                    eg = 2'b01;
                end
                default: begin
                    drive(0, 0, 0, 0, WT_WORD, 0, 0);
                    drive(1, 0, 0, 0, WT_WORD, 0, 0);
                end
            endcase
            #1;
            erv = 2'b00;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                erv = e.who ? 2'b10 : 2'b01;
            end
            n_chk++;
            if ({r1.rvalid, r0.rvalid} !== erv)
                $display("FAIL midlock_rvalid k=%0d got %b want %b", k, {r1.rvalid, r0.rvalid}, erv);
            else n_pass++;
            if (erv != 2'b00) begin
                got = e.who ? r1.rdata : r0.rdata;
                n_chk++;
                if (got !== e.data)
                    $display("FAIL midlock_rdata k=%0d got %h want %h", k, got, e.data);
                else n_pass++;
            end
            n_chk++;
            if ({r1.gnt, r0.gnt} !== eg)
                $display("FAIL midlock_gnt k=%0d got %b want %b", k, {r1.gnt, r0.gnt}, eg);
            else n_pass++;
            if (eg == 2'b01) sb.push_back('{1'b0, pat(k == 0 ? 32'h10 : 32'h30)});
            if (eg == 2'b10) sb.push_back('{1'b1, pat(k == 1 ? 32'h24 : 32'h28)});
            if (k == 2) begin
                rst = 1'b1;
                #1;
                n_chk++;
                if ({r1.gnt, r0.gnt} !== 2'b00 || mem_addr !== 32'h0)
                    $display("FAIL midlock_rst_gnt got %b addr=%h want 00/0", {r1.gnt, r0.gnt}, mem_addr);
                else n_pass++;
                sb.delete();
            end
        end
    endtask

`ifdef DMEM_ARB_STATS_EN
    task automatic test_stats;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        drive(0, 1, 0, 0, WT_WORD, 32'h10, 0);
        drive(1, 1, 0, 0, WT_WORD, 32'h20, 0);
        repeat (10) tick;
        drive(0, 0, 0, 0, WT_WORD, 0, 0);
        drive(1, 0, 0, 0, WT_WORD, 0, 0);
        tick;
        sb.delete();
        n_chk++;
        if (stat_conflict !== 32'd10)
            $display("FAIL stat_conflict got %0d want 10", stat_conflict);
        else n_pass++;
        n_chk++;
        if (stat_gnt0 !== 32'd5 || stat_gnt1 !== 32'd5)
            $display("FAIL stat_gnt got %0d/%0d want 5/5", stat_gnt0, stat_gnt1);
        else n_pass++;
    endtask
`endif

    initial begin
        drive(0, 0, 0, 0, WT_WORD, 0, 0);
        drive(1, 0, 0, 0, WT_WORD, 0, 0);
        test_reset;
        test_contention;
        test_solo;
        test_lock_expiry;
        test_midlock_reset;
`ifdef DMEM_ARB_STATS_EN
        test_stats;
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single data-memory port (`MEM`: write enable, 3-bit write type, address, write data, read data) between requester 0 (CPU load/store path) and requester 1 (debug/DMA loader). It sits between the requesters and the data memory, multiplexes one access per cycle onto the memory, and returns read data with a registered valid. Arbitration is round-robin under contention, with an optional bounded lock for multi-access sequences.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `LOCK_MAX`, 16, maximum consecutive cycles a locked owner may hold the port (≥ 1)

Ports. Requester ports are replicated per requester `n` ∈ {0,1}; suffix `_n`.
- `clk`  in  1  clock. One clock domain; reset is synchronous and active-high.
- `rst`  in  1  synchronous reset, active-high
- `req_n`  in  1  access request
- `lock_n`  in  1  hold ownership after this grant
- `we_n`  in  1  1 = store, 0 = load
- `wtype_n`  in  3  write/read type, passed through unchanged
- `addr_n`  in  ADDR_W  byte address
- `wdata_n`  in  DATA_W  store data
- `gnt_n`  out  1  access accepted this cycle (combinational)
- `rvalid_n`  out  1  load data valid (registered)
- `rdata_n`  out  DATA_W  load data; valid only when `rvalid_n` is high
- `mem_we`  out  1  to memory
- `mem_wtype`  out  3  to memory
- `mem_addr`  out  ADDR_W  to memory
- `mem_wdata`  out  DATA_W  to memory
- `mem_rdata`  in  DATA_W  from memory; valid one cycle after the address is presented

## Operation
- State register `own` ∈ {IDLE, OWN0, OWN1}. Also holds a priority pointer `prio` (1 bit) and a lock counter `lcnt` (width clog2(LOCK_MAX+1)).
- Per-cycle winner selection, in priority order:
  1. **Locked owner.** If `own`=OWNn, `req_n`=1 and `lcnt` < LOCK_MAX, then n wins.
  2. **Contention.** Else, if both requesters request, `prio` wins and `prio` flips.
  3. **Single request.** Else, if exactly one requests, it wins; `prio` is unchanged.
  4. **No request.** Else there is no winner.
- Winner n: `gnt_n`=1 and the memory outputs are driven from requester n. With no winner, all memory outputs are 0.
- State update:
  - Winner n with `lock_n`=1 → `own`=OWNn.
  - Otherwise → `own`=IDLE.
  - `lcnt` increments while the owner is unchanged and locked; it clears on any ownership change or IDLE.
  - When `lcnt` reaches LOCK_MAX, the lock is ignored for one arbitration. If the other requester is waiting, it must win that cycle.
- Owner drops `req` while locked → `own`=IDLE the next cycle, and the other requester may win immediately.
- Stores produce no `rvalid`.
- A granted load sets `rvalid_n`=1 the following cycle, with `rdata_n`=`mem_rdata`. `rdata` of the non-valid requester is 0.
- The winner's `addr`, `wdata`, `wtype` and `we` are not registered; the requester must hold them stable during the grant cycle.

## Timing
- **Reset values:** `own`=IDLE, `prio`=0, `lcnt`=0, `rvalid_0`=`rvalid_1`=0, `rdata_n`=0. All memory outputs are 0 while `rst` is high, and all `gnt_n`=0.
- **Grant latency:** 0 cycles (same cycle as `req`).
- **Load latency:** 1 cycle from grant to `rvalid`.
- **Throughput:** one access per cycle. Back-to-back loads from alternating requesters each return exactly one cycle after their own grant.
- **Handshake:** `req_n` stays high until `gnt_n`; an ungranted request is not recorded.
- **Reset mid-operation:** a pending `rvalid` is dropped and the lock is released.

## Configuration
- `DMEM_ARB_STATS_EN` defined: adds outputs `stat_gnt0`, `stat_gnt1` and `stat_conflict`, each 32 bits.
  - `stat_gntn` counts grants to requester n.
  - `stat_conflict` counts cycles where both requested.
  - All three wrap at 2^32 and clear on `rst`.
- Undefined: these ports and counters are absent, and the arbitration behaviour is identical.

## Structure
- Package `dmem_arb_pkg` holds:
  - the `own` state enum (IDLE/OWN0/OWN1)
  - write-type constants shared with the memory: byte = 3'b000, half = 3'b001, word = 3'b010, byte-unsigned = 3'b100, half-unsigned = 3'b101
- Sub-module `dmem_arb_lock_timer` contains the `lcnt` counter and the expiry compare.
- Winner select, muxes and `rvalid` registers stay in the top.

## Test plan
- **Reset:** assert `rst` with both `req` high → all `gnt`=0, `mem_we`=0, `rvalid`=0. After release, `prio`=0, so requester 0 wins first.
- **Contention:** both request loads continuously, `lock`=0 → grants alternate 0,1,0,1. Each `rvalid_n` comes one cycle after its grant, with data from `addr_n`.
- **Solo requester:** requester 1 alone stores word 0xDEADBEEF to 0x40, then loads 0x40 → `mem_we`=1 and `mem_wtype`=3'b010 in the store cycle; `rdata_1`=0xDEADBEEF one cycle after the load grant.
- **Lock expiry:** requester 0 locks and requests continuously with LOCK_MAX=4, while requester 1 requests → requester 0 is granted for the first 5 cycles, and requester 1 is granted on the 6th.
- **Mid-lock reset:** `rst` pulsed while OWN1 with a load just granted → `rvalid_1` stays 0 and the next arbitration starts from IDLE with `prio`=0.
- **Stats (`DMEM_ARB_STATS_EN`):** 10 cycles of dual requests → `stat_conflict`=10 and `stat_gnt0`=`stat_gnt1`=5.
